// File: rtl/audio_bit_serializer.sv
// One-word holding register feeding a DATA_W shifter. Each bit is held for
// CLK_DIV clocks and sent MSB or LSB first. Outputs come from registers.
module audio_bit_serializer #(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              pdm_audio_o,
  output logic              pdm_sdaudio_o,
  output logic              done_o,
  output logic              underrun_o,
  output logic              busy_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t            state_r, state_next_s;
  logic              hold_full_r, hold_full_next_s;
  logic [DATA_W-1:0] hold_data_r;
  logic [DATA_W-1:0] shift_r, shift_next_s;
  logic [DIV_W-1:0]  div_cnt_r, div_next_s;
  logic [BIT_W-1:0]  bit_cnt_r, bit_next_s;
  logic              ready_r, pdm_r, done_r, underrun_r, busy_r, sdaudio_r;
  logic              accept_s, load_s, done_s, underrun_s, cur_bit_s;

  assign accept_s = valid_i && ready_r;

  // Bit currently presented by the shifter, honouring the configured order.
  always_comb begin
    cur_bit_s = 1'b0;
    if (MSB_FIRST != 0) begin
      cur_bit_s = shift_r[DATA_W-1];
    end else begin
      cur_bit_s = shift_r[0];
    end
  end

  // Next-state logic: bit-period and bit-index counting, word end, reload.
  always_comb begin
    state_next_s = state_r;
    div_next_s   = div_cnt_r;
    bit_next_s   = bit_cnt_r;
    shift_next_s = shift_r;
    load_s       = 1'b0;
    done_s       = 1'b0;
    underrun_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable_i && hold_full_r) begin
          load_s       = 1'b1;
          state_next_s = ST_SHIFT;
          div_next_s   = {DIV_W{1'b0}};
          bit_next_s   = {BIT_W{1'b0}};
          shift_next_s = hold_data_r;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // A pause clears the period count so the interrupted bit restarts whole.
        if (!enable_i) begin
          div_next_s = {DIV_W{1'b0}};
        end else if (div_cnt_r != DIV_LAST) begin
          div_next_s = div_cnt_r + DIV_W'(1);
        end else begin
          div_next_s = {DIV_W{1'b0}};
          if (bit_cnt_r != BIT_LAST) begin
            bit_next_s = bit_cnt_r + BIT_W'(1);
            if (MSB_FIRST != 0) begin
              shift_next_s = {shift_r[DATA_W-2:0], 1'b0};
            end else begin
              shift_next_s = {1'b0, shift_r[DATA_W-1:1]};
            end
          end else begin
            done_s     = 1'b1;
            bit_next_s = {BIT_W{1'b0}};
            if (hold_full_r) begin
              load_s       = 1'b1;
              shift_next_s = hold_data_r;
            end else begin
              underrun_s   = 1'b1;
              state_next_s = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Holding register occupancy: loading the shifter empties it.
  always_comb begin
    hold_full_next_s = hold_full_r;
    if (load_s) begin
      hold_full_next_s = 1'b0;
    end else if (accept_s) begin
      hold_full_next_s = 1'b1;
    end else begin
      hold_full_next_s = hold_full_r;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r     <= ST_IDLE;
      hold_full_r <= 1'b0;
      hold_data_r <= {DATA_W{1'b0}};
      shift_r     <= {DATA_W{1'b0}};
      div_cnt_r   <= {DIV_W{1'b0}};
      bit_cnt_r   <= {BIT_W{1'b0}};
      ready_r     <= 1'b1;
      pdm_r       <= 1'b0;
      done_r      <= 1'b0;
      underrun_r  <= 1'b0;
      busy_r      <= 1'b0;
      sdaudio_r   <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      hold_full_r <= hold_full_next_s;
      if (accept_s) begin
        hold_data_r <= data_i;
      end
      shift_r     <= shift_next_s;
      div_cnt_r   <= div_next_s;
      bit_cnt_r   <= bit_next_s;
      ready_r     <= !hold_full_next_s;
      pdm_r       <= (state_r == ST_SHIFT) && enable_i && cur_bit_s;
      done_r      <= done_s;
      underrun_r  <= underrun_s;
      busy_r      <= (state_r == ST_SHIFT);
      sdaudio_r   <= 1'b1;
    end
  end

  // The pipeline lags enable_i by a clock, so pause-sensitive outputs are gated.
  assign ready_o       = ready_r;
  assign pdm_audio_o   = pdm_r & enable_i;
  assign done_o        = done_r & enable_i;
  assign underrun_o    = underrun_r & enable_i;
  assign busy_o        = busy_r;
  assign pdm_sdaudio_o = sdaudio_r;

endmodule

// File: tb/tb_audio_bit_serializer.sv
// Directed bench: four serializer configurations sharing clock and reset.
module tb_audio_bit_serializer;

  logic clk_s = 1'b0;
  logic rst_n_s;

  logic en_a_s, val_a_s, rdy_a_s, pdm_a_s, sd_a_s, done_a_s, und_a_s, busy_a_s;
  logic en_b_s, val_b_s, rdy_b_s, pdm_b_s, sd_b_s, done_b_s, und_b_s, busy_b_s;
  logic en_c_s, val_c_s, rdy_c_s, pdm_c_s, sd_c_s, done_c_s, und_c_s, busy_c_s;
  logic en_d_s, val_d_s, rdy_d_s, pdm_d_s, sd_d_s, done_d_s, und_d_s, busy_d_s;
  logic [15:0] dat_a_s, dat_b_s, dat_c_s, dat_d_s;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk_s = ~clk_s;

  audio_bit_serializer #(.DATA_W(16), .CLK_DIV(1), .MSB_FIRST(1)) u_a (
    .clock_i(clk_s), .reset_ni(rst_n_s), .enable_i(en_a_s), .data_i(dat_a_s),
    .valid_i(val_a_s), .ready_o(rdy_a_s), .pdm_audio_o(pdm_a_s),
    .pdm_sdaudio_o(sd_a_s), .done_o(done_a_s), .underrun_o(und_a_s), .busy_o(busy_a_s));

  audio_bit_serializer #(.DATA_W(16), .CLK_DIV(1), .MSB_FIRST(0)) u_b (
    .clock_i(clk_s), .reset_ni(rst_n_s), .enable_i(en_b_s), .data_i(dat_b_s),
    .valid_i(val_b_s), .ready_o(rdy_b_s), .pdm_audio_o(pdm_b_s),
    .pdm_sdaudio_o(sd_b_s), .done_o(done_b_s), .underrun_o(und_b_s), .busy_o(busy_b_s));

  audio_bit_serializer #(.DATA_W(16), .CLK_DIV(4), .MSB_FIRST(1)) u_c (
    .clock_i(clk_s), .reset_ni(rst_n_s), .enable_i(en_c_s), .data_i(dat_c_s),
    .valid_i(val_c_s), .ready_o(rdy_c_s), .pdm_audio_o(pdm_c_s),
    .pdm_sdaudio_o(sd_c_s), .done_o(done_c_s), .underrun_o(und_c_s), .busy_o(busy_c_s));

  audio_bit_serializer #(.DATA_W(16), .CLK_DIV(2), .MSB_FIRST(1)) u_d (
    .clock_i(clk_s), .reset_ni(rst_n_s), .enable_i(en_d_s), .data_i(dat_d_s),
    .valid_i(val_d_s), .ready_o(rdy_d_s), .pdm_audio_o(pdm_d_s),
    .pdm_sdaudio_o(sd_d_s), .done_o(done_d_s), .underrun_o(und_d_s), .busy_o(busy_d_s));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus changes and output sampling both happen on the falling edge.
  initial begin
    logic [15:0] pat_a;
    logic [15:0] pat_b;
    logic [15:0] words [5];
    logic [15:0] rxq [$];
    logic [15:0] rx;
    int nbits, idx, n_done, n_und, exp_bit, n_bad;

    words[0] = 16'h1234; words[1] = 16'hBEEF; words[2] = 16'h0F0F;
    words[3] = 16'h8001; words[4] = 16'h7FFE;
    pat_a = 16'hA5C3;
    pat_b = 16'h0001;

    rst_n_s = 1'b0;
    en_a_s = 1'b1; en_b_s = 1'b1; en_c_s = 1'b1; en_d_s = 1'b1;
    val_a_s = 1'b0; val_b_s = 1'b0; val_c_s = 1'b0; val_d_s = 1'b0;
    dat_a_s = 16'h0000; dat_b_s = 16'h0000; dat_c_s = 16'h0000; dat_d_s = 16'h0000;

    #12;
    check_eq("rst_ready", {31'd0, rdy_a_s}, 32'd1);
    check_eq("rst_pdm", {31'd0, pdm_a_s}, 32'd0);
    check_eq("rst_done", {31'd0, done_a_s}, 32'd0);
    check_eq("rst_underrun", {31'd0, und_a_s}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_a_s}, 32'd0);
    check_eq("rst_sdaudio", {31'd0, sd_a_s}, 32'd1);

    // Word presented on the same falling edge that reset is released.
    @(negedge clk_s);
    rst_n_s = 1'b1;
    val_a_s = 1'b1; dat_a_s = pat_a;
    val_b_s = 1'b1; dat_b_s = pat_b;
    @(negedge clk_s);
    check_eq("a_ready_after_accept", {31'd0, rdy_a_s}, 32'd0);
    val_a_s = 1'b0; val_b_s = 1'b0;
    @(negedge clk_s);
    check_eq("a_latency_pdm", {31'd0, pdm_a_s}, 32'd0);
    check_eq("a_latency_busy", {31'd0, busy_a_s}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_s);
      check_eq("a_bit", {31'd0, pdm_a_s}, {31'd0, pat_a[15-i]});
      check_eq("a_done", {31'd0, done_a_s}, {31'd0, (i == 15)});
      check_eq("a_underrun", {31'd0, und_a_s}, {31'd0, (i == 15)});
      check_eq("a_busy", {31'd0, busy_a_s}, 32'd1);
      check_eq("b_bit", {31'd0, pdm_b_s}, {31'd0, pat_b[i]});
      check_eq("b_done", {31'd0, done_b_s}, {31'd0, (i == 15)});
    end
    @(negedge clk_s);
    check_eq("a_busy_fall", {31'd0, busy_a_s}, 32'd0);
    check_eq("a_idle_pdm", {31'd0, pdm_a_s}, 32'd0);
    check_eq("b_busy_fall", {31'd0, busy_b_s}, 32'd0);

    // CLK_DIV=4: FFFF then 0000 back-to-back, 0000 waits for ready.
    val_c_s = 1'b1; dat_c_s = 16'hFFFF;
    @(negedge clk_s);
    check_eq("c_ready_full", {31'd0, rdy_c_s}, 32'd0);
    dat_c_s = 16'h0000;
    @(negedge clk_s);
    check_eq("c_ready_after_load", {31'd0, rdy_c_s}, 32'd1);
    @(negedge clk_s);
    check_eq("c_ready_second", {31'd0, rdy_c_s}, 32'd0);
    val_c_s = 1'b0;
    for (int k = 3; k <= 130; k++) begin
      if (k != 3) @(negedge clk_s);
      check_eq("c_bit", {31'd0, pdm_c_s}, {31'd0, (k <= 66)});
      check_eq("c_done", {31'd0, done_c_s}, {31'd0, (k == 66 || k == 130)});
      check_eq("c_underrun", {31'd0, und_c_s}, {31'd0, (k == 130)});
    end
    @(negedge clk_s);
    check_eq("c_busy_fall", {31'd0, busy_c_s}, 32'd0);

    // CLK_DIV=2: pause for 10 clocks during the second clock of bit 5.
    val_d_s = 1'b1; dat_d_s = pat_a;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk_s);
      if (k == 1) val_d_s = 1'b0;
      if (k < 3 || (k >= 14 && k <= 23) || k == 46) exp_bit = 0;
      else if (k <= 13) exp_bit = int'(pat_a[15 - (k - 3) / 2]);
      else if (k <= 25) exp_bit = int'(pat_a[10]);
      else exp_bit = int'(pat_a[15 - (6 + (k - 26) / 2)]);
      check_eq("d_bit", {31'd0, pdm_d_s}, exp_bit[31:0]);
      check_eq("d_done", {31'd0, done_d_s}, {31'd0, (k == 45)});
      check_eq("d_underrun", {31'd0, und_d_s}, {31'd0, (k == 45)});
      if (k == 13) begin
        en_d_s = 1'b0;
        #1;
        check_eq("d_pause_immediate", {31'd0, pdm_d_s}, 32'd0);
      end
      if (k == 20) check_eq("d_busy_in_pause", {31'd0, busy_d_s}, 32'd1);
      if (k == 23) en_d_s = 1'b1;
    end
    check_eq("d_busy_fall", {31'd0, busy_d_s}, 32'd0);

    // valid_i held high across five words; scoreboard the serial stream.
    rx = 16'h0000; nbits = 0; idx = 0; n_done = 0; n_und = 0;
    for (int t = 0; t < 120; t++) begin
      @(negedge clk_s);
      if (busy_a_s) begin
        rx = {rx[14:0], pdm_a_s};
        nbits++;
        if (nbits == 16) begin
          rxq.push_back(rx);
          nbits = 0;
        end
      end
      if (done_a_s) n_done++;
      if (und_a_s) n_und++;
      if (idx < 5) begin
        val_a_s = 1'b1;
        dat_a_s = words[idx];
        if (rdy_a_s) idx++;
      end else begin
        val_a_s = 1'b0;
      end
    end
    check_eq("sb_accepted", idx[31:0], 32'd5);
    check_eq("sb_received", rxq.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < rxq.size()) check_eq("sb_word", {16'd0, rxq[i]}, {16'd0, words[i]});
      else check_eq("sb_word_missing", 32'd0, 32'd1);
    end
    check_eq("sb_done_count", n_done[31:0], 32'd5);
    check_eq("sb_underrun_count", n_und[31:0], 32'd1);

    // Asynchronous reset mid-clock during bit 8 with a second word held.
    val_a_s = 1'b1; dat_a_s = 16'hFFFF;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk_s);
      if (k == 3) val_a_s = 1'b0;
    end
    check_eq("r_bit8", {31'd0, pdm_a_s}, 32'd1);
    check_eq("r_hold_full", {31'd0, rdy_a_s}, 32'd0);
    #2 rst_n_s = 1'b0;
    #1;
    check_eq("r_ready", {31'd0, rdy_a_s}, 32'd1);
    check_eq("r_pdm", {31'd0, pdm_a_s}, 32'd0);
    check_eq("r_busy", {31'd0, busy_a_s}, 32'd0);
    check_eq("r_done", {31'd0, done_a_s}, 32'd0);
    check_eq("r_underrun", {31'd0, und_a_s}, 32'd0);
    check_eq("r_sdaudio", {31'd0, sd_a_s}, 32'd1);
    @(negedge clk_s);
    @(negedge clk_s);
    rst_n_s = 1'b1;
    n_bad = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk_s);
      if (done_a_s || und_a_s || busy_a_s || pdm_a_s || !rdy_a_s) n_bad++;
    end
    check_eq("r_quiet_after_release", n_bad[31:0], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
